// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam logic [3:0]  COL_RESET = 4'b1110;

  typedef enum logic [1:0] {
    StScan,
    StDbDown,
    StHeld,
    StDbUp
  } state_e;

  function automatic logic [3:0] key_code(input logic [1:0] row_idx, input logic [1:0] col_idx);
    return {row_idx, col_idx};
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider; tick_o is high on the last cycle of every SCAN_DIV-cycle column slot.
module scan_tick_gen #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned   CntW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == CntMax);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: synchronises rows, debounces press and release,
// and emits one press pulse with the key code per debounced key-down.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic       press_o,
  output logic [3:0] scan_code_o,
  output logic       key_valid_o
);

  localparam int unsigned    DbW   = $clog2(DEBOUNCE + 1);
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE);

  logic           tick;
  logic [3:0]     row_meta_q, rs_q;
  state_e         state_q, state_d;
  logic [3:0]     col_q, col_d;
  logic [DbW-1:0] dbc_q, dbc_d, dbc_inc;
  logic [1:0]     row_idx_q, row_idx_d, col_idx_q, col_idx_d;
  logic           press_q, press_d, key_valid_q, key_valid_d;
  logic [3:0]     scan_code_q, scan_code_d;
  logic [1:0]     low_row, cur_col;
  logic           row_hit;
  logic [3:0]     col_rot;

  scan_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tick_o(tick)
  );

  // Lowest-indexed low row wins; descending loop leaves the smallest index last.
  always_comb begin
    low_row = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rs_q[i]) low_row = 2'(i);
    end
  end

  always_comb begin
    cur_col = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (!col_q[i]) cur_col = 2'(i);
    end
  end

  assign row_hit = ~rs_q[row_idx_q];
  assign col_rot = {col_q[2:0], col_q[3]};
  assign dbc_inc = dbc_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    dbc_d       = dbc_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    press_d     = 1'b0;
    key_valid_d = key_valid_q;
    scan_code_d = scan_code_q;
    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (&rs_q) begin
            col_d = col_rot;
          end else begin
            row_idx_d = low_row;
            col_idx_d = cur_col;
            dbc_d     = '0;
            state_d   = StDbDown;
          end
        end
        StDbDown: begin
          if (row_hit) begin
            dbc_d = dbc_inc;
            if (dbc_inc == DbMax) begin
              scan_code_d = key_code(row_idx_q, col_idx_q);
              press_d     = 1'b1;
              key_valid_d = 1'b1;
              state_d     = StHeld;
            end
          end else begin
            col_d   = col_rot;
            state_d = StScan;
          end
        end
        StHeld: begin
          if (!row_hit) begin
            dbc_d = DbW'(1);
            if (DbMax == DbW'(1)) begin
              key_valid_d = 1'b0;
              col_d       = col_rot;
              state_d     = StScan;
            end else begin
              state_d = StDbUp;
            end
          end
        end
        StDbUp: begin
          if (!row_hit) begin
            dbc_d = dbc_inc;
            if (dbc_inc == DbMax) begin
              key_valid_d = 1'b0;
              col_d       = col_rot;
              state_d     = StScan;
            end
          end else begin
            dbc_d   = '0;
            state_d = StHeld;
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_meta_q  <= 4'hF;
      rs_q        <= 4'hF;
      state_q     <= StScan;
      col_q       <= COL_RESET;
      dbc_q       <= '0;
      row_idx_q   <= '0;
      col_idx_q   <= '0;
      press_q     <= 1'b0;
      key_valid_q <= 1'b0;
      scan_code_q <= 4'h0;
    end else begin
      row_meta_q  <= row_i;
      rs_q        <= row_meta_q;
      state_q     <= state_d;
      col_q       <= col_d;
      dbc_q       <= dbc_d;
      row_idx_q   <= row_idx_d;
      col_idx_q   <= col_idx_d;
      press_q     <= press_d;
      key_valid_q <= key_valid_d;
      scan_code_q <= scan_code_d;
    end
  end

  assign col_o       = col_q;
  assign press_o     = press_q;
  assign scan_code_o = scan_code_q;
  assign key_valid_o = key_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scenario bench for keypad_scanner with a behavioural 4x4 keypad and a press scoreboard.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row, col, code;
  logic        press, kv;
  logic [15:0] keys = '0;  // bit r*4+c set = key at row r / column c pressed

  int          errors = 0;
  int          checks = 0;
  int          press_cnt = 0;
  logic [3:0]  sb[$];
  logic [3:0]  exp_code;
  logic        press_prev = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE(3)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .row_i      (row),
    .col_o      (col),
    .press_o    (press),
    .scan_code_o(code),
    .key_valid_o(kv)
  );

  always @(negedge clk) begin
    if (press) begin
      press_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_press: scan_code=%h, no press was due", code);
      end else begin
        exp_code = sb.pop_front();
        if (code !== exp_code || kv !== 1'b1) begin
          errors++;
          $display("FAIL press_code: scan_code=%h key_valid=%b, required %h/1", code, kv, exp_code);
        end
      end
      if (press_prev) begin
        checks++;
        errors++;
        $display("FAIL press_width: press high for two cycles, required one");
      end
    end
    press_prev <= press;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for the start of the slot where col == v.
  task automatic wait_slot(input logic [3:0] v, input string name);
    int n = 0;
    while (col === v && n < 40) begin @(negedge clk); n++; end
    while (col !== v && n < 40) begin @(negedge clk); n++; end
    if (col !== v) begin
      checks++;
      errors++;
      $display("FAIL %s: col=%b, required %b within 40 cycles", name, col, v);
    end
  endtask

  task automatic wait_kv(input logic v, input int budget, input string name);
    int n = 0;
    while (kv !== v && n < budget) begin @(negedge clk); n++; end
    if (kv !== v) begin
      checks++;
      errors++;
      $display("FAIL %s: key_valid=%b, required %b within %0d cycles", name, kv, v, budget);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    rst  = 1'b1;
    keys = '0;
    cycles(3);
    checks += 4;
    if (col !== 4'b1110) begin errors++; $display("FAIL rst_col: %b, required 1110", col); end
    if (press !== 1'b0) begin errors++; $display("FAIL rst_press: %b, required 0", press); end
    if (code !== 4'h0) begin errors++; $display("FAIL rst_code: %h, required 0", code); end
    if (kv !== 1'b0) begin errors++; $display("FAIL rst_kv: %b, required 0", kv); end
    rst     = 1'b0;
    exp_col = 4'b1110;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (j % 4 == 0) exp_col = {exp_col[2:0], exp_col[3]};
      checks++;
      if (col !== exp_col) begin
        errors++;
        $display("FAIL idle_rotate: cycle %0d col=%b, required %b", j, col, exp_col);
      end
    end
  endtask

  task automatic test_clean_press();
    int p0 = press_cnt;
    wait_slot(4'b1101, "clean_slot");
    keys[2*4+1] = 1'b1;
    sb.push_back(4'h9);
    cycles(100);
    checks += 3;
    if (press_cnt - p0 != 1) begin errors++; $display("FAIL clean_count: %0d presses, required 1", press_cnt - p0); end
    if (kv !== 1'b1) begin errors++; $display("FAIL clean_kv: %b, required 1", kv); end
    if (code !== 4'h9) begin errors++; $display("FAIL clean_code: %h, required 9", code); end
    keys = '0;
    cycles(4);
    checks++;
    if (kv !== 1'b1) begin errors++; $display("FAIL clean_kv_hold: %b, required 1", kv); end
    wait_kv(1'b0, 40, "clean_release");
    checks++;
    if (col !== 4'b1011) begin errors++; $display("FAIL clean_resume: col=%b, required 1011", col); end
  endtask

  task automatic test_bounce();
    int p0 = press_cnt;
    wait_slot(4'b1101, "bounce_slot");
    keys[2*4+1] = 1'b1;
    cycles(8);
    keys = '0;
    cycles(4);
    checks += 4;
    if (col !== 4'b1011) begin errors++; $display("FAIL bounce_col: %b, required 1011", col); end
    if (press_cnt != p0) begin errors++; $display("FAIL bounce_press: %0d presses, required 0", press_cnt - p0); end
    if (code !== 4'h9) begin errors++; $display("FAIL bounce_code: %h, required 9", code); end
    if (kv !== 1'b0) begin errors++; $display("FAIL bounce_kv: %b, required 0", kv); end
  endtask

  task automatic test_release_bounce();
    int p0 = press_cnt;
    wait_slot(4'b0111, "rb_slot");
    keys[3*4+3] = 1'b1;
    sb.push_back(4'hF);
    wait_kv(1'b1, 40, "rb_press");
    keys = '0;
    cycles(4);
    checks++;
    if (kv !== 1'b1) begin errors++; $display("FAIL rb_kv_up1: %b, required 1", kv); end
    keys[3*4+3] = 1'b1;
    cycles(4);
    checks++;
    if (kv !== 1'b1) begin errors++; $display("FAIL rb_kv_glitch: %b, required 1", kv); end
    keys = '0;
    cycles(8);
    checks++;
    if (kv !== 1'b1) begin errors++; $display("FAIL rb_kv_up2: %b, required 1", kv); end
    cycles(4);
    checks += 4;
    if (kv !== 1'b0) begin errors++; $display("FAIL rb_kv_off: %b, required 0", kv); end
    if (col !== 4'b1110) begin errors++; $display("FAIL rb_col: %b, required 1110", col); end
    if (press_cnt - p0 != 1) begin errors++; $display("FAIL rb_count: %0d presses, required 1", press_cnt - p0); end
    if (code !== 4'hF) begin errors++; $display("FAIL rb_code: %h, required F", code); end
  endtask

  task automatic test_simultaneous();
    int p0 = press_cnt;
    wait_slot(4'b1110, "sim_slot");
    keys[1*4+0] = 1'b1;
    keys[3*4+0] = 1'b1;
    sb.push_back(4'h4);
    wait_kv(1'b1, 40, "sim_press");
    keys[0*4+2] = 1'b1;
    cycles(40);
    checks += 3;
    if (press_cnt - p0 != 1) begin errors++; $display("FAIL sim_count: %0d presses, required 1", press_cnt - p0); end
    if (code !== 4'h4) begin errors++; $display("FAIL sim_code: %h, required 4", code); end
    if (col !== 4'b1110) begin errors++; $display("FAIL sim_frozen: col=%b, required 1110", col); end
    keys[1*4+0] = 1'b0;
    keys[3*4+0] = 1'b0;
    sb.push_back(4'h2);
    wait_kv(1'b0, 40, "sim_release");
    checks++;
    if (col !== 4'b1101) begin errors++; $display("FAIL sim_resume: col=%b, required 1101", col); end
    wait_kv(1'b1, 60, "sim_second_key");
    checks++;
    if (code !== 4'h2) begin errors++; $display("FAIL sim_code2: %h, required 2", code); end
    keys = '0;
    wait_kv(1'b0, 40, "sim_release2");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    wait_slot(4'b1110, "rm_slot");
    keys[0] = 1'b1;
    cycles(8);
    rst = 1'b1;
    cycles(2);
    checks += 4;
    if (col !== 4'b1110) begin errors++; $display("FAIL rm_col: %b, required 1110", col); end
    if (press !== 1'b0) begin errors++; $display("FAIL rm_press: %b, required 0", press); end
    if (code !== 4'h0) begin errors++; $display("FAIL rm_code: %h, required 0", code); end
    if (kv !== 1'b0) begin errors++; $display("FAIL rm_kv: %b, required 0", kv); end
    rst = 1'b0;
    sb.push_back(4'h0);
    while (press !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    checks += 2;
    if (n != 16) begin errors++; $display("FAIL rm_latency: press after %0d cycles, required 16", n); end
    if (kv !== 1'b1) begin errors++; $display("FAIL rm_kv_on: %b, required 1", kv); end
    keys = '0;
    wait_kv(1'b0, 40, "rm_release");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_simultaneous();
    test_reset_mid();
    cycles(10);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d presses outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
